// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory controller.
// Controller state encoding, default geometry and the NOP used for faulting fetches.
package imem_pkg;

    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/imem_load_seq.sv
// Loader byte sequencer: write pointer, byte count and overflow tracking.
// Latency: writes are issued combinationally in the beat's cycle; pointer updates at the edge.
// Backpressure: ld_ready low outside LOAD and during a restart cycle; beats past DEPTH are dropped.
module imem_load_seq
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              clear,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              accept,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W:0]   ptr,
    output logic              ld_overflow
);

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

    logic full;

    assign full      = (ptr == DEPTH_P);
    assign ld_ready  = active & ~ld_start;
    assign accept    = ld_valid & ld_ready;
    assign mem_we    = accept & ~full;
    assign mem_wdata = ld_data;

    // Pointer doubles as the byte count: it only advances on a real write and saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr         <= '0;
            ld_overflow <= 1'b0;
        end else if (accept) begin
            if (full) begin
                ld_overflow <= 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: boot loader / core fetch arbitration (optional IMEM_FETCH_CHECK_EN fault check).
// Latency: fetch response one cycle after an accepted request; ld_done one cycle after the last beat.
// Backpressure: core held via core_hold outside RUN; loader accepted only in LOAD.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_inst,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_overflow,
    output logic [ADDR_W:0]   ld_count,
    output logic              core_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t state, state_nxt;
    logic in_load, in_run, in_drain;
    logic accept, seq_clear, fetch_acc, fetch_fault;
    logic [ADDR_W:0] ptr;

    assign in_load  = (state == LOAD);
    assign in_run   = (state == RUN);
    assign in_drain = (state == DRAIN);

    assign core_hold = ~in_run;
    assign seq_clear = in_drain | (in_load & ld_start);
    assign fetch_acc = in_run & fetch_req & ~ld_start;
    assign ld_count  = ptr;
    assign mem_addr  = in_run ? fetch_addr[ADDR_W-1:0] : ptr[ADDR_W-1:0];

    imem_load_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_load_seq (
        .clk         (clk),
        .rst         (rst),
        .active      (in_load),
        .clear       (seq_clear),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .accept      (accept),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .ptr         (ptr),
        .ld_overflow (ld_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT_LOAD ? LOAD : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (ld_start) state_nxt = DRAIN;
            DRAIN:   state_nxt = LOAD;
            LOAD:    if (accept && ld_last) state_nxt = RUN;
            default: state_nxt = LOAD;
        endcase
    end

`ifdef IMEM_FETCH_CHECK_EN
    assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr > 32'(DEPTH - 4));

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= fetch_acc & fetch_fault;
        end
    end
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^fetch_addr[31:ADDR_W];
    assign fetch_fault    = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    // fetch_inst keeps its last value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_inst  <= '0;
            ld_done     <= 1'b0;
        end else begin
            fetch_valid <= fetch_acc;
            ld_done     <= in_load & accept & ld_last;
            if (fetch_acc) begin
                fetch_inst <= fetch_fault ? NOP_INST : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a byte-array memory attached to the mem_* port.
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        fetch_err;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_overflow;
    logic [10:0] ld_count;
    logic        core_hold;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we0;

    logic [7:0] mem [0:1023];
    bit         mem_inited = 1'b0;
    logic [7:0] prog [4] = '{8'h00, 8'h10, 8'h03, 8'h13};

`ifdef IMEM_FETCH_CHECK_EN
    localparam logic [31:0] EXP_INST_2   = 32'h00000013;
    localparam logic [31:0] EXP_INST_3FD = 32'h00000013;
    localparam logic        EXP_ERR      = 1'b1;
`else
    localparam logic [31:0] EXP_INST_2   = 32'h03130405;
    localparam logic [31:0] EXP_INST_3FD = 32'hFDFEFF00;
    localparam logic        EXP_ERR      = 1'b0;
`endif

    always #5 clk = ~clk;

    imem_ctrl #(
        .DEPTH     (1024),
        .ADDR_W    (10),
        .BOOT_LOAD (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_err   (fetch_err),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .ld_overflow (ld_overflow),
        .ld_count    (ld_count),
        .core_hold   (core_hold),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Memory preloaded with mem[i] = i so untouched words are easy to predict.
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 1024; i++) mem[i] <= i[7:0];
            mem_inited <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
    end

    assign mem_rdata = {mem[mem_addr], mem[mem_addr + 10'd1],
                        mem[mem_addr + 10'd2], mem[mem_addr + 10'd3]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_start   = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_core_hold", core_hold, 1);
        check("rst_ld_count", ld_count, 0);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_ld_done", ld_done, 0);
        check("rst_ld_overflow", ld_overflow, 0);
        check("rst_fetch_err", fetch_err, 0);
        tick();
        rst = 1'b0;

        // Boot load of 00 10 03 13
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == 3);
            @(negedge clk);
            check("boot_we", mem_we, 1);
            check("boot_addr", mem_addr, i);
            tick();
        end
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        @(negedge clk);
        check("boot_ld_done", ld_done, 1);
        check("boot_core_hold", core_hold, 0);
        check("boot_ld_count", ld_count, 4);
        tick();

        // Back-to-back fetch 0, 4, 8
        fetch_addr = 32'h4;
        @(negedge clk);
        check("b2b_valid0", fetch_valid, 1);
        check("b2b_inst0", fetch_inst, 32'h00100313);
        check("b2b_done_low", ld_done, 0);
        tick();
        fetch_addr = 32'h8;
        @(negedge clk);
        check("b2b_valid1", fetch_valid, 1);
        check("b2b_inst1", fetch_inst, 32'h04050607);
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        check("b2b_valid2", fetch_valid, 1);
        check("b2b_inst2", fetch_inst, 32'h08090A0B);
        tick();
        @(negedge clk);
        check("idle_valid", fetch_valid, 0);
        check("idle_inst_hold", fetch_inst, 32'h08090A0B);

        // Reload during run
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        tick();
        ld_start   = 1'b1;
        fetch_addr = 32'h8;
        @(negedge clk);
        check("rl_start_hold", core_hold, 0);
        check("rl_prev_valid", fetch_valid, 1);
        check("rl_prev_inst", fetch_inst, 32'h04050607);
        tick();
        ld_start = 1'b0;
        @(negedge clk);
        check("rl_drain_no_resp", fetch_valid, 0);
        check("rl_drain_hold", core_hold, 1);
        check("rl_drain_ready", ld_ready, 0);
        tick();
        @(negedge clk);
        check("rl_load_count", ld_count, 0);
        check("rl_load_hold", core_hold, 1);
        check("rl_load_ready", ld_ready, 1);
        check("rl_load_no_fetch", fetch_valid, 0);
        fetch_req = 1'b0;
        tick();

        // Restart inside LOAD
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        check("rs_count2", ld_count, 2);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_data  = 8'hCC;
        @(negedge clk);
        check("rs_ready_low", ld_ready, 0);
        check("rs_we_low", mem_we, 0);
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        check("rs_count_clr", ld_count, 0);
        check("rs_still_load", core_hold, 1);
        for (int i = 0; i < 4; i++) send_byte(prog[i], i == 3);
        @(negedge clk);
        check("rs_done", ld_done, 1);
        check("rs_count4", ld_count, 4);

        // Fetch at 0x2 and 0x3FD
        fetch_req  = 1'b1;
        fetch_addr = 32'h2;
        tick();
        fetch_addr = 32'h3FD;
        @(negedge clk);
        check("fc_valid_2", fetch_valid, 1);
        check("fc_inst_2", fetch_inst, EXP_INST_2);
        check("fc_err_2", fetch_err, EXP_ERR);
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        check("fc_valid_3fd", fetch_valid, 1);
        check("fc_inst_3fd", fetch_inst, EXP_INST_3FD);
        check("fc_err_3fd", fetch_err, EXP_ERR);
        tick();

        // Overflow: DEPTH+2 bytes
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        tick();
        we0 = we_cnt;
        for (int i = 0; i < 1026; i++) begin
            ld_valid = 1'b1;
            ld_data  = i[7:0] ^ 8'hA5;
            ld_last  = (i == 1025);
            if (i == 1024) begin
                @(negedge clk);
                check("ov_drop_we", mem_we, 0);
                check("ov_count_sat", ld_count, 1024);
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        check("ov_count", ld_count, 1024);
        check("ov_flag", ld_overflow, 1);
        check("ov_done", ld_done, 1);
        check("ov_we_pulses", we_cnt - we0, 1024);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        tick();
        @(negedge clk);
        check("ov_flag_clr", ld_overflow, 0);
        check("ov_count_clr", ld_count, 0);
        tick();

        // Reset mid-load
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        check("rml_count3", ld_count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rml_count", ld_count, 0);
        check("rml_hold", core_hold, 1);
        check("rml_ready", ld_ready, 1);
        check("rml_no_done", ld_done, 0);
        tick();
        @(negedge clk);
        check("rml_no_done2", ld_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
